spart_bus_arbiter: RTL
======================

# spart_bus_arbiter

Two-port arbiter and transaction sequencer for the SPART processor-side bus (iocs/iorw/ioaddr/databus). It lets two independent clients share one SPART: typically port 0 is the configuration client and port 1 is the data client. Each client issues single-byte transactions through a req/ack handshake. The block grants ports round-robin, holds data-register accesses until the SPART is ready (tbr for writes, rda for reads), drives one bus cycle, and returns read data or a timeout error.

## Interface
- TIMEOUT, default 255: maximum WAIT cycles before aborting; 0 = wait forever; legal range 0..255.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req0, req1  in  1  transaction request; held until ack
- we0, we1  in  1  1 = write, 0 = read; held with req
- addr0, addr1  in  2  SPART register address; held with req
- wdata0, wdata1  in  8  write data; held with req
- ack0, ack1  out  1  one-cycle completion pulse
- rdata0, rdata1  out  8  read data, valid while ack is high
- err0, err1  out  1  timeout flag, valid while ack is high
- iocs  out  1  SPART chip select
- iorw  out  1  1 = read, 0 = write
- ioaddr  out  2  SPART register address
- databus  inout  8  driven only when iocs=1 and iorw=0, otherwise high-Z
- rda  in  1  receive data available
- tbr  in  1  transmit buffer ready

## Operation
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE: sample req0/req1.
  - If exactly one request is high, grant that port.
  - If both are high, grant the port not granted last.
  - On a grant, latch that port's we/addr/wdata into the transaction registers, clear the wait counter, update the last-granted pointer, and go to WAIT.
- WAIT: compute ready.
  - addr=00 with write: ready = tbr.
  - addr=00 with read: ready = rda.
  - addr 01/10/11: ready = 1.
  - If ready, go to ACCESS.
  - Else if TIMEOUT≠0 and counter == TIMEOUT-1, go to DONE with err=1. No bus cycle is issued.
  - Else increment the counter (8-bit; it cannot wrap given the TIMEOUT range).
- ACCESS: for exactly one cycle drive iocs=1, iorw=~we, ioaddr=latched addr, and databus=latched wdata on writes. On a read, capture databus into the read register at the closing edge. Go to DONE with err=0.
- DONE: pulse the granted port's ack for one cycle with rdata and err. The other port's ack stays 0. Go to IDLE.
- Client rule: deassert req on the edge where ack is sampled high. A req still high in IDLE after DONE counts as a new transaction.
- Port fields are latched at grant time. Changes to them after the grant are ignored.
- rdata of a non-granted port holds its previous value.
- Reset values:
  - iocs=0, iorw=1, ioaddr=00, databus high-Z.
  - ack0/1=0, err0/1=0, rdata0/1=00.
  - state IDLE, counter 0, last-granted = port 1, so port 0 wins the first tie.
- rst asserted in any state: the next edge returns everything to reset values. The in-flight transaction is dropped with no ack and no further bus cycle.

## Timing
- Minimum latency with the SPART ready: req high in cycle 0 → WAIT in cycle 1 → iocs high in cycle 2 → ack high in cycle 3.
- Each not-ready WAIT cycle adds one cycle.
- Timeout path: ack with err=1 arrives TIMEOUT+1 cycles after the grant edge. iocs never rises.
- Back-to-back: the next grant is evaluated in the IDLE cycle after DONE, so the maximum throughput is one transaction per 4 cycles.
- iocs is high for exactly one cycle per transaction. databus is driven only in that cycle.
- All outputs are registered.

## Structure
- Package spart_bus_pkg holds:
  - state encoding: IDLE=2'b00, WAIT=2'b01, ACCESS=2'b10, DONE=2'b11.
  - address constants: ADDR_DATA=2'b00, ADDR_STATUS=2'b01, ADDR_DB_LOW=2'b10, ADDR_DB_HIGH=2'b11.
- Sub-module rr_arb2 is a two-requester round-robin arbiter with a registered last-grant pointer and an update enable driven from IDLE.
- The FSM, wait counter, transaction registers and tristate driver live in the top module.

## Test plan
- Reset, then req0 write addr=10 data=8'h16 → iocs=1, iorw=0, ioaddr=10, databus=16 in cycle 2; ack0 in cycle 3; err0=0.
- req1 read addr=00 with rda=0 for 5 cycles then 1, SPART returns 8'hA5 → iocs rises 1 cycle after rda goes high; ack1 with rdata1=A5 and err1=0.
- req0 and req1 raised in the same cycle, then both re-raised after each ack → grant order is 0, 1, 0, 1; never two acks in one cycle.
- TIMEOUT=4, req1 write addr=00 with tbr held 0 → ack1 with err1=1 five cycles after the grant edge; iocs stays 0 throughout.
- rst asserted during WAIT, and separately during ACCESS → next edge gives iocs=0, iorw=1, databus high-Z; no ack follows; a fresh req0 afterwards completes normally.
- Port fields changed after the grant (addr 01→11) → bus shows the latched addr 01.

Source files
------------

// File: rtl/spart_bus_pkg.sv
// Shared types and constants for the SPART bus arbiter: FSM encoding,
// SPART register addresses, and the per-access readiness rule.
package spart_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT   = 2'b01,
        ACCESS = 2'b10,
        DONE   = 2'b11
    } state_e;

    localparam logic [1:0] ADDR_DATA    = 2'b00;
    localparam logic [1:0] ADDR_STATUS  = 2'b01;
    localparam logic [1:0] ADDR_DB_LOW  = 2'b10;
    localparam logic [1:0] ADDR_DB_HIGH = 2'b11;

    // Only the data register is gated by the SPART; status and divisor
    // registers can be accessed at any time.
    function automatic logic spart_ready(input logic       we,
                                         input logic [1:0] addr,
                                         input logic       tbr,
                                         input logic       rda);
        logic rdy;
        rdy = 1'b1;
        if (addr == ADDR_DATA) begin
            rdy = we ? tbr : rda;
        end
        return rdy;
    endfunction

endpackage

// File: rtl/spart_bus_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. Grant is combinational from req and
// the registered last-grant pointer; the pointer only moves when upd_en is high.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd_en,
    output logic [1:0] gnt
);

    logic last_q, last_d;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (upd_en && (|req)) begin
            last_d = gnt[1];
        end
    end

    // Pointer resets to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/spart_bus_arbiter.sv
// Two-port SPART bus arbiter: round-robin grant, readiness wait with
// optional timeout, one-cycle bus access, registered ack/rdata/err per port.
module spart_bus_arbiter
    import spart_bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [1:0] addr0,
    input  logic [1:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic       err0,
    output logic       err1,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    input  logic       rda,
    input  logic       tbr
);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       port_q, port_d;
    logic       we_q, we_d;
    logic [1:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       iocs_q, iocs_d;
    logic       iorw_q, iorw_d;
    logic [1:0] ioaddr_q, ioaddr_d;
    logic       ack0_q, ack0_d, ack1_q, ack1_d;
    logic       err0_q, err0_d, err1_q, err1_d;
    logic [7:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic [1:0] gnt;
    logic       arb_en;
    logic       ready;
    logic       timeout_hit;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1, req0}),
        .upd_en (arb_en),
        .gnt    (gnt)
    );

    assign arb_en      = (state_q == IDLE);
    assign ready       = spart_ready(we_q, addr_q, tbr, rda);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        port_d   = port_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        iocs_d   = 1'b0;
        iorw_d   = 1'b1;
        ioaddr_d = 2'b00;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    port_d  = gnt[1];
                    we_d    = gnt[1] ? we1    : we0;
                    addr_d  = gnt[1] ? addr1  : addr0;
                    wdata_d = gnt[1] ? wdata1 : wdata0;
                    cnt_d   = 8'd0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (ready) begin
                    // Bus outputs are registered, so they are set up on the
                    // edge that enters ACCESS.
                    state_d  = ACCESS;
                    iocs_d   = 1'b1;
                    iorw_d   = ~we_q;
                    ioaddr_d = addr_q;
                end else if (timeout_hit) begin
                    state_d = DONE;
                    ack0_d  = ~port_q;
                    ack1_d  = port_q;
                    err0_d  = ~port_q;
                    err1_d  = port_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ACCESS: begin
                state_d = DONE;
                ack0_d  = ~port_q;
                ack1_d  = port_q;
                if (!we_q) begin
                    if (port_q) rdata1_d = databus;
                    else        rdata0_d = databus;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            port_q   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 2'b00;
            wdata_q  <= 8'h00;
            iocs_q   <= 1'b0;
            iorw_q   <= 1'b1;
            ioaddr_q <= 2'b00;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= 8'h00;
            rdata1_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            port_q   <= port_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            iocs_q   <= iocs_d;
            iorw_q   <= iorw_d;
            ioaddr_q <= ioaddr_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign databus = (iocs_q && !iorw_q) ? wdata_q : 8'hzz;

    assign iocs   = iocs_q;
    assign iorw   = iorw_q;
    assign ioaddr = ioaddr_q;
    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign err0   = err0_q;
    assign err1   = err1_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule
